// File: rtl/hfrv_uart_pkg.sv
// Shared types and constants for the hf-riscv UART receive path.
package hfrv_uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  // Counter value at which the middle of a bit period is reached.
  function automatic int mid_bit_cnt(input int clks_per_bit);
    return clks_per_bit / 2 - 1;
  endfunction

endpackage

// File: rtl/hfrv_uart_rx_if.sv
// Bus-side bundle of the UART receiver: serial line, pop/clear strobes, FIFO head and status.
// parity_err exists only when HFRV_UART_RX_PARITY_EN is defined.
interface hfrv_uart_rx_if
  import hfrv_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic                      rx;
  logic                      rd_en;
  logic                      clr_err;
  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic [LEVEL_W-1:0]        rx_level;
  logic                      frame_err;
  logic                      overrun;
`ifdef HFRV_UART_RX_PARITY_EN
  logic                      parity_err;

  modport master (output rx, rd_en, clr_err,
                  input  rx_data, rx_valid, rx_level, frame_err, overrun, parity_err);
  modport slave  (input  rx, rd_en, clr_err,
                  output rx_data, rx_valid, rx_level, frame_err, overrun, parity_err);
`else
  modport master (output rx, rd_en, clr_err,
                  input  rx_data, rx_valid, rx_level, frame_err, overrun);
  modport slave  (input  rx, rd_en, clr_err,
                  output rx_data, rx_valid, rx_level, frame_err, overrun);
`endif

endinterface

// File: rtl/hfrv_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; pointers carry one extra wrap bit.
module hfrv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       pop_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             pop_ok, push_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;

  assign pop_ok  = pop_i && !empty_o;
  // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push.
  assign push_ok = push_i && (!full_o || pop_ok);

  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/hfrv_uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, FWFT receive FIFO and sticky error flags.
// Defining HFRV_UART_RX_PARITY_EN adds an even-parity bit and the parity_err flag.
module hfrv_uart_rx
  import hfrv_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           reset,
  hfrv_uart_rx_if.slave  bus
);
  localparam int          LEVEL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] CNT_MID  = 16'(mid_bit_cnt(CLKS_PER_BIT));
  localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);

  rx_state_t                 state_q, state_d;
  logic [15:0]               cnt_q, cnt_d;
  logic [2:0]                bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      rx_meta_q, rx_s_q;
  logic                      frame_err_q, frame_err_d;
  logic                      overrun_q, overrun_d;
  logic                      push, set_frame, fifo_full;
  logic [LEVEL_W-1:0]        fifo_level;
  logic                      fifo_empty;
`ifdef HFRV_UART_RX_PARITY_EN
  logic                      par_bad_q, par_bad_d;
  logic                      parity_err_q, parity_err_d;
  logic                      set_par;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push      = 1'b0;
    set_frame = 1'b0;
`ifdef HFRV_UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    set_par   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[UART_DATA_BITS-1:1]};
          bit_d   = bit_q + 3'd1;
`ifdef HFRV_UART_RX_PARITY_EN
          if (bit_q == 3'd7) state_d = PARITY;
`else
          if (bit_q == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef HFRV_UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          par_bad_d = rx_s_q != (^shift_q);
          set_par   = par_bad_d;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
`ifdef HFRV_UART_RX_PARITY_EN
            push = !par_bad_q;
`else
            push = 1'b1;
`endif
            state_d = IDLE;
          end else begin
            set_frame = 1'b1;
            state_d   = BREAK;
          end
        end
      end
      // Hold here until the line returns high so a stuck-low line is not decoded as 0x00 frames.
      BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    frame_err_d = set_frame | (frame_err_q & ~bus.clr_err);
    overrun_d   = (push & fifo_full & ~bus.rd_en) | (overrun_q & ~bus.clr_err);
`ifdef HFRV_UART_RX_PARITY_EN
    parity_err_d = set_par | (parity_err_q & ~bus.clr_err);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef HFRV_UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      rx_meta_q   <= bus.rx;
      rx_s_q      <= rx_meta_q;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef HFRV_UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  hfrv_sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (reset),
    .push_i      (push),
    .push_data_i (shift_q),
    .pop_i       (bus.rd_en),
    .pop_data_o  (bus.rx_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level)
  );

  assign bus.rx_valid  = !fifo_empty;
  assign bus.rx_level  = fifo_level;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
`ifdef HFRV_UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_hfrv_uart_rx.sv
// Directed bench for hfrv_uart_rx (CLKS_PER_BIT=16, FIFO_DEPTH=4); honours HFRV_UART_RX_PARITY_EN.
module tb_hfrv_uart_rx;
  import hfrv_uart_pkg::*;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef HFRV_UART_RX_PARITY_EN
  localparam int NBITS = 11;
  logic flip_par = 1'b0;
`else
  localparam int NBITS = 10;
`endif
  // Cycle offset, from the start-bit negedge, whose following posedge is the stop-sample push.
  localparam int PUSH_C = NBITS * CPB - 6;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hfrv_uart_rx_if #(.FIFO_DEPTH(DEPTH)) bus();

  hfrv_uart_rx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop1();
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input bit pop_at_push, input bit clr_at_push);
    logic [NBITS-1:0] frame;
`ifdef HFRV_UART_RX_PARITY_EN
    frame = {stop, (^d) ^ flip_par, d, 1'b0};
`else
    frame = {stop, d, 1'b0};
`endif
    for (int c = 0; c < NBITS * CPB; c++) begin
      bus.rx      = frame[c / CPB];
      bus.rd_en   = pop_at_push && (c == PUSH_C);
      bus.clr_err = clr_at_push && (c == PUSH_C);
      @(negedge clk);
    end
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  initial begin
    logic [9:0] part;
    reset       = 1'b1;
    bus.rx      = 1'b1;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_data",     32'(bus.rx_data),   32'h00);
    check("rst_valid",    32'(bus.rx_valid),  32'h0);
    check("rst_level",    32'(bus.rx_level),  32'h0);
    check("rst_frame",    32'(bus.frame_err), 32'h0);
    check("rst_overrun",  32'(bus.overrun),   32'h0);

    // two clean frames, popped in order
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b0, 1'b0);
    tick(4);
    check("t1_valid",  32'(bus.rx_valid), 32'h1);
    check("t1_level2", 32'(bus.rx_level), 32'h2);
    check("t1_head55", 32'(bus.rx_data),  32'h55);
    pop1();
    check("t1_headA3", 32'(bus.rx_data),  32'hA3);
    check("t1_level1", 32'(bus.rx_level), 32'h1);
    pop1();
    check("t1_level0", 32'(bus.rx_level), 32'h0);
    check("t1_empty",  32'(bus.rx_valid), 32'h0);
    check("t1_frame",  32'(bus.frame_err), 32'h0);
    pop1();
    check("t1_pop_empty_level", 32'(bus.rx_level), 32'h0);

    // short low glitch while idle
    bus.rx = 1'b0;
    tick(4);
    bus.rx = 1'b1;
    tick(40);
    check("t2_state", 32'(dut.state_q), 32'(IDLE));
    check("t2_valid", 32'(bus.rx_valid), 32'h0);
    check("t2_level", 32'(bus.rx_level), 32'h0);

    // bad stop bit, long break, then a good frame
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    tick(40 * CPB);
    check("t3_frame_set",  32'(bus.frame_err), 32'h1);
    check("t3_no_byte",    32'(bus.rx_level),  32'h0);
    check("t3_break",      32'(dut.state_q),   32'(BREAK));
    bus.rx = 1'b1;
    tick(32);
    check("t3_idle",       32'(dut.state_q),   32'(IDLE));
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
    tick(4);
    check("t3_level1",     32'(bus.rx_level),  32'h1);
    check("t3_head7E",     32'(bus.rx_data),   32'h7E);
    check("t3_frame_keep", 32'(bus.frame_err), 32'h1);
    pop1();
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    check("t3_frame_clr",  32'(bus.frame_err), 32'h0);

    // fill, overrun with clr_err on the same cycle, then push+pop while full
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
    tick(2);
    check("t4_full_level", 32'(bus.rx_level), 32'h4);
    check("t4_no_ovr_yet", 32'(bus.overrun),  32'h0);
    send_frame(8'h05, 1'b1, 1'b0, 1'b1);
    tick(2);
    check("t5_set_wins",   32'(bus.overrun),  32'h1);
    check("t4_level4",     32'(bus.rx_level), 32'h4);
    check("t4_head01",     32'(bus.rx_data),  32'h01);
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    check("t5_ovr_clr",    32'(bus.overrun),  32'h0);
    send_frame(8'h06, 1'b1, 1'b1, 1'b0);
    tick(2);
    check("t4_pushpop_ovr",   32'(bus.overrun),  32'h0);
    check("t4_pushpop_level", 32'(bus.rx_level), 32'h4);
    check("t4_head02",        32'(bus.rx_data),  32'h02);
    pop1();
    check("t4_head03",        32'(bus.rx_data),  32'h03);
    pop1();
    check("t4_head04",        32'(bus.rx_data),  32'h04);
    pop1();
    check("t4_head06",        32'(bus.rx_data),  32'h06);
    pop1();
    check("t4_drained",       32'(bus.rx_level), 32'h0);

    // reset in the middle of a data bit, with one byte already queued
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    tick(2);
    check("t6_pre_level", 32'(bus.rx_level), 32'h1);
    part = {1'b1, 8'h99, 1'b0};
    for (int c = 0; c < 5 * CPB; c++) begin
      bus.rx = part[c / CPB];
      @(negedge clk);
    end
    reset  = 1'b1;
    bus.rx = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("t6_level0",  32'(bus.rx_level), 32'h0);
    check("t6_data0",   32'(bus.rx_data),  32'h00);
    tick(10 * CPB);
    check("t6_nothing", 32'(bus.rx_valid), 32'h0);
    send_frame(8'h42, 1'b1, 1'b0, 1'b0);
    tick(4);
    check("t6_level1",  32'(bus.rx_level), 32'h1);
    check("t6_head42",  32'(bus.rx_data),  32'h42);
    pop1();

`ifdef HFRV_UART_RX_PARITY_EN
    flip_par = 1'b1;
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    flip_par = 1'b0;
    tick(4);
    check("t7_parity_err", 32'(bus.parity_err), 32'h1);
    check("t7_discarded",  32'(bus.rx_level),   32'h0);
    check("t7_frame_ok",   32'(bus.frame_err),  32'h0);
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    check("t7_parity_clr", 32'(bus.parity_err), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
